board_snapshot_fetcher: RTL and testbench

//   Sits between dmem port B (chess_address/chess_data) and the VGA pixel path.
//   On each frame_start pulse it streams the 64 board squares out of dmem into a shadow bank.

---
 rtl/chess_pkg.sv | 21 ++
 rtl/board_bank.sv | 36 +++
 rtl/board_snapshot_fetcher.sv | 94 +++++++++
 tb/tb_board_snapshot_fetcher.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// chess_pkg: board constants, piece encodings and fetcher FSM states shared with the VGA renderer
package chess_pkg;
  localparam int PIECE_W = 4;
  localparam int NUM_SQUARES = 64;
  typedef enum logic [3:0] {
    EMPTY    = 4'd0,
    W_PAWN   = 4'd1,
    W_KNIGHT = 4'd2,
    W_BISHOP = 4'd3,
    W_ROOK   = 4'd4,
    W_QUEEN  = 4'd5,
    W_KING   = 4'd6,
    B_PAWN   = 4'd9,
    B_KNIGHT = 4'd10,
    B_BISHOP = 4'd11,
    B_ROOK   = 4'd12,
    B_QUEEN  = 4'd13,
    B_KING   = 4'd14
  } piece_e;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, COMMIT} fetch_state_e;
endpackage

// File: rtl/board_bank.sv
// board_bank: shadow/active square register pair with indexed write, one-cycle bulk commit and registered read
//   clk_i, rst_i        clock, async active-high reset (clears both banks and the read register)
//   wr_en_i/wr_idx_i/wr_data_i  write one square of the shadow bank
//   commit_i            copy the whole shadow bank into the active bank
//   rd_idx_i, rd_data_o registered lookup of the active bank
module board_bank #(
  parameter int N = 64,
  parameter int W = 4,
  localparam int IW = $clog2(N)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_en_i,
  input  logic [IW-1:0] wr_idx_i,
  input  logic [W-1:0]  wr_data_i,
  input  logic          commit_i,
  input  logic [IW-1:0] rd_idx_i,
  output logic [W-1:0]  rd_data_o
);
  logic [W-1:0] shadow_q [N];
  logic [W-1:0] active_q [N];
  logic [W-1:0] rd_q;
  // Reads see the pre-commit active bank in the commit cycle (non-blocking update).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
      rd_q <= '0;
    end else begin
      if (wr_en_i) shadow_q[wr_idx_i] <= wr_data_i;
      if (commit_i) active_q <= shadow_q;
      rd_q <= active_q[rd_idx_i];
    end
  end
  assign rd_data_o = rd_q;
endmodule

// File: rtl/board_snapshot_fetcher.sv
// board_snapshot_fetcher: streams the board out of dmem port B each frame and commits it tear-free for the pixel path
//   clk_i, rst_i        shared clock, async active-high reset
//   frame_start_i       start-of-vblank pulse that launches a fetch
//   chess_address_o     dmem port B read address; chess_data_i its read data (RD_LAT cycles later)
//   square_idx_i        pixel-path lookup index; piece_code_o registered active-bank contents
//   snapshot_valid_o    sticky after first commit; busy_o fetch in flight
//   fetch_done_o        commit-cycle pulse; frame_overrun_o frame_start seen while busy
module board_snapshot_fetcher
  import chess_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] BOARD_BASE = '0,
  parameter int NUM_SQUARES = chess_pkg::NUM_SQUARES,
  parameter int PIECE_W = chess_pkg::PIECE_W,
  parameter int RD_LAT = 2,
  localparam int SW = $clog2(NUM_SQUARES)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               frame_start_i,
  output logic [ADDR_W-1:0]  chess_address_o,
  input  logic [DATA_W-1:0]  chess_data_i,
  input  logic [SW-1:0]      square_idx_i,
  output logic [PIECE_W-1:0] piece_code_o,
  output logic               snapshot_valid_o,
  output logic               busy_o,
  output logic               fetch_done_o,
  output logic               frame_overrun_o
);
  localparam int CW = SW + 1;
  fetch_state_e state_q, state_d;
  logic [CW-1:0] issue_q, issue_d, cap_q, cap_d;
  logic [RD_LAT-1:0] pipe_q, pipe_d;
  logic valid_q, valid_d;
  logic capture;
  logic unused_data;
  assign unused_data = ^chess_data_i[DATA_W-1:PIECE_W];
  // A tag leaves the pipe exactly when the data for that read is on chess_data_i.
  assign capture = pipe_q[RD_LAT-1];
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      issue_q <= '0;
      cap_q <= '0;
      pipe_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      issue_q <= issue_d;
      cap_q <= cap_d;
      pipe_q <= pipe_d;
      valid_q <= valid_d;
    end
  end
  always_comb begin
    state_d = state_q;
    issue_d = issue_q;
    cap_d = cap_q + CW'(capture);
    pipe_d = RD_LAT'({pipe_q, state_q == ISSUE});
    valid_d = valid_q;
    case (state_q)
      IDLE: if (frame_start_i) begin
        state_d = ISSUE;
        issue_d = '0;
        cap_d = '0;
      end
      ISSUE: if (issue_q == CW'(NUM_SQUARES - 1)) state_d = DRAIN;
        else issue_d = issue_q + CW'(1);
      DRAIN: if (cap_q == CW'(NUM_SQUARES)) state_d = COMMIT;
      COMMIT: begin
        state_d = IDLE;
        valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // issue_q parks on the last index through DRAIN, so the address holds its final value.
  assign chess_address_o = (state_q == IDLE) ? BOARD_BASE : BOARD_BASE + ADDR_W'(issue_q);
  assign busy_o = state_q != IDLE;
  assign fetch_done_o = state_q == COMMIT;
  assign frame_overrun_o = frame_start_i & busy_o;
  assign snapshot_valid_o = valid_q;
  board_bank #(.N(NUM_SQUARES), .W(PIECE_W)) u_bank (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .wr_en_i(capture),
    .wr_idx_i(cap_q[SW-1:0]),
    .wr_data_i(chess_data_i[PIECE_W-1:0]),
    .commit_i(fetch_done_o),
    .rd_idx_i(square_idx_i),
    .rd_data_o(piece_code_o)
  );
endmodule

// File: tb/tb_board_snapshot_fetcher.sv
// tb_board_snapshot_fetcher: four fetcher configurations (RD_LAT 2/1/3, base 000 and FE0) against a snapshot model
module tb_board_snapshot_fetcher;
  logic clk, rst, frame_start;
  logic [5:0] sq;
  logic [31:0] mem [4096];
  logic [11:0] addr [4];
  logic [3:0] pc [4];
  logic valid [4];
  logic busy [4];
  logic done [4];
  logic ovr [4];
  int n_cmp = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : inst
    localparam int L = (g == 1) ? 1 : (g == 2) ? 3 : 2;
    localparam logic [11:0] B = (g == 3) ? 12'hFE0 : 12'h000;
    localparam int DONE = 64 + L + 1;
    logic [31:0] dq [L];
    board_snapshot_fetcher #(.BOARD_BASE(B), .RD_LAT(L)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .frame_start_i(frame_start),
      .chess_address_o(addr[g]),
      .chess_data_i(dq[L-1]),
      .square_idx_i(sq),
      .piece_code_o(pc[g]),
      .snapshot_valid_o(valid[g]),
      .busy_o(busy[g]),
      .fetch_done_o(done[g]),
      .frame_overrun_o(ovr[g])
    );
    // dmem port B: L-stage registered read
    always @(posedge clk) begin
      dq[0] <= mem[addr[g]];
      for (int i = 1; i < L; i++) dq[i] <= dq[i-1];
    end
    // Model: age counts cycles since the accepting edge; square k holds what memory had when it was read at age k.
    int age;
    logic [3:0] snap [64];
    logic [3:0] act [64];
    logic mvalid;
    logic [3:0] mpc;
    always @(posedge clk or posedge rst) begin
      if (rst) begin
        age <= -1;
        mvalid <= 1'b0;
        mpc <= 4'h0;
        for (int i = 0; i < 64; i++) act[i] <= 4'h0;
      end else begin
        mpc <= act[sq];
        if (age < 0) begin
          if (frame_start) age <= 0;
        end else if (age == DONE) begin
          age <= -1;
          mvalid <= 1'b1;
          for (int i = 0; i < 64; i++) act[i] <= snap[i];
        end else begin
          if (age < 64) snap[age[5:0]] <= mem[12'(B + age)][3:0];
          age <= age + 1;
        end
      end
    end
    always @(negedge clk) begin
      if (!rst) begin
        if (age != DONE)
          chk($sformatf("addr%0d", g), 32'(addr[g]), 32'((age < 0) ? B : (age < 64) ? 12'(B + age) : 12'(B + 63)));
        chk($sformatf("busy%0d", g), 32'(busy[g]), 32'(age >= 0));
        chk($sformatf("done%0d", g), 32'(done[g]), 32'(age == DONE));
        chk($sformatf("ovr%0d", g), 32'(ovr[g]), 32'(frame_start && age >= 0));
        chk($sformatf("valid%0d", g), 32'(valid[g]), 32'(mvalid));
        chk($sformatf("pc%0d", g), 32'(pc[g]), 32'(mpc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy[0] | busy[1] | busy[2] | busy[3]) && n < 400) begin
      tick();
      n++;
    end
    chk("idle_reached", 32'(n < 400), 32'd1);
  endtask

  task automatic lookup(input string nm, input int g, input logic [5:0] s, input logic [3:0] exp);
    sq = s;
    tick();
    @(negedge clk);
    chk(nm, 32'(pc[g]), 32'(exp));
    #1;
  endtask

  initial begin
    int n;
    int nd;
    for (int a = 0; a < 4096; a++)
      mem[a] = (a < 64) ? 32'hABCD0000 + 32'(a) : 32'hFFFF0000 + 32'((a * 5 + 3) % 16);
    rst = 1'b1;
    frame_start = 1'b0;
    sq = 6'd12;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("t2_pc_before", 32'(pc[0]), 32'd0);
    chk("t2_valid_before", 32'(valid[0]), 32'd0);
    #1;
    pulse_fs();
    n = 0;
    @(negedge clk);
    while (!done[0] && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("t1_latency", 32'(n), 32'd67);
    #1;
    wait_idle();
    lookup("t1_sq5", 0, 6'd5, 4'h5);
    chk("t2_valid_after", 32'(valid[0]), 32'd1);
    chk("t1_lat1_sq5", 32'(pc[1]), 32'd5);
    chk("t1_lat3_sq5", 32'(pc[2]), 32'd5);
    chk("t5_sq5", 32'(pc[3]), 32'd12);
    lookup("t5_sq0", 3, 6'd0, 4'd3);
    lookup("t5_sq31", 3, 6'd31, 4'd14);
    lookup("t5_sq32", 3, 6'd32, 4'd0);
    pulse_fs();
    repeat (10) tick();
    frame_start = 1'b1;
    @(negedge clk);
    chk("t3_overrun", 32'(ovr[0]), 32'd1);
    tick();
    frame_start = 1'b0;
    @(negedge clk);
    chk("t3_overrun_end", 32'(ovr[0]), 32'd0);
    nd = 0;
    repeat (120) begin
      @(negedge clk);
      if (done[0]) nd++;
    end
    chk("t3_one_done", 32'(nd), 32'd1);
    chk("t2_valid_sticky", 32'(valid[0]), 32'd1);
    #1;
    wait_idle();
    mem[3] = 32'h6;
    sq = 6'd3;
    pulse_fs();
    wait_idle();
    pulse_fs();
    mem[3] = 32'hE;
    n = 0;
    @(negedge clk);
    while (!done[0] && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("t4_in_commit", 32'(pc[0]), 32'd6);
    @(negedge clk);
    chk("t4_after_commit", 32'(pc[0]), 32'd6);
    @(negedge clk);
    chk("t4_new", 32'(pc[0]), 32'd14);
    #1;
    wait_idle();
    pulse_fs();
    repeat (30) tick();
    rst = 1'b1;
    #1;
    chk("t6_addr", 32'(addr[0]), 32'd0);
    chk("t6_addr_fe0", 32'(addr[3]), 32'hFE0);
    chk("t6_pc", 32'(pc[0]), 32'd0);
    chk("t6_valid", 32'(valid[0]), 32'd0);
    chk("t6_busy", 32'(busy[0]), 32'd0);
    chk("t6_done", 32'(done[0]), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("t6_pc_after", 32'(pc[0]), 32'd0);
    chk("t6_valid_after", 32'(valid[0]), 32'd0);
    #1;
    sq = 6'd5;
    pulse_fs();
    wait_idle();
    lookup("t6_refetch_sq5", 0, 6'd5, 4'h5);
    chk("t6_valid_refetch", 32'(valid[0]), 32'd1);
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
